seq_match_logger: RTL and testbench
===================================

# seq_match_logger

Downstream consumer of the sequence detector's 1-bit `match` pulse. Timestamps every match against a free-running cycle counter, buffers the timestamps in a small FIFO drained through a valid/ready port, and keeps a saturating total match count plus a sticky overflow flag. It sits between the detector and whatever host or trace logic reads match events.

## Interface
- `TS_W`, 16: width of the free-running timestamp counter and of each FIFO entry.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CNT_W`, 16: width of the saturating match counter.

- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = in reset).
- `match`  in  1  detector output; each cycle it is high is one match event.
- `clear`  in  1  synchronous flush of FIFO, counter, overflow and timestamp.
- `out_valid`  out  1  FIFO non-empty; `out_ts` is valid.
- `out_ready`  in  1  consumer accepts head entry when `out_valid` is also 1.
- `out_ts`  out  TS_W  timestamp of oldest unread match.
- `fill`  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- `match_count`  out  CNT_W  total matches seen, saturating.
- `overflow`  out  1  sticky: a match was dropped because FIFO was full.

## Operation
- Timestamp `ts`: register, +1 every cycle, wraps 2^TS_W−1 → 0. A push stores the value `ts` holds in the cycle `match` is high (pre-increment value).
- Push: `match`=1 and (not full, or full with pop in same cycle). Pop: `out_valid`=1 and `out_ready`=1.
- Full with `match`=1 and no pop: entry dropped, `overflow` set to 1, FIFO unchanged.
- Full, `match`=1 and pop in same cycle: both happen, `fill` stays DEPTH, no drop.
- Empty, `match`=1: push only; pop impossible (out_valid=0); no bypass.
- `match_count`: +1 on every cycle `match`=1, whether pushed or dropped; holds at 2^CNT_W−1.
- `overflow`: cleared only by `clear` or reset.
- `clear`=1: next edge sets FIFO empty, `fill`=0, `match_count`=0, `overflow`=0, `ts`=0. `clear` beats `match` and pop in the same cycle: the match is neither stored nor counted, no pop occurs.
- FIFO: circular buffer, read/write pointers with one extra wrap bit; full = pointers equal except wrap bit. Storage need not be reset; `out_ts` is don't-care when `out_valid`=0.

## Timing
- Reset (async assert, sync-safe deassert): `ts`=0, `fill`=0, `out_valid`=0, `match_count`=0, `overflow`=0; `out_ts` don't-care.
- Reset asserted mid-operation: all of the above immediately; buffered entries are lost.
- Latency match → `out_valid`: 1 cycle (match in cycle N, `out_valid`=1 and `out_ts` valid from cycle N+1).
- Pop takes effect at the edge; next entry presented the following cycle; back-to-back pops sustain 1 entry/cycle.
- `out_valid`, `out_ts`, `fill`, `match_count`, `overflow` are all registered or decoded from registers only; no combinational path from `out_ready` or `match` to any output.
- `out_ts` must stay stable while `out_valid`=1 and `out_ready`=0.

## Test plan
- Reset release, `match`=1 in the cycle `ts`=5, `out_ready`=0 → next cycle `out_valid`=1, `out_ts`=5, `fill`=1, `match_count`=1.
- Matches at `ts`=2,3,4,7 with `out_ready`=0, then `out_ready`=1 → pops 2,3,4,7 on consecutive cycles, then `out_valid`=0, `fill`=0.
- DEPTH=4 full, 5th match with `out_ready`=0 → dropped, `overflow`=1, `fill`=4, `match_count`=5; then match plus pop in same cycle → `fill`=4, no further drop, head advances.
- `clear`=1 together with `match`=1 while `fill`=3, `match_count`=9, `overflow`=1 → next cycle all zero, `out_valid`=0, `ts`=0.
- TS_W=4: match at `ts`=15 and the next cycle → entries 15 then 0 (wrap); CNT_W=2 with 5 matches → `match_count` holds 3.
- Async `reset`=0 mid-drain with `fill`=2 → outputs reset values without waiting for clock; after release, first match timestamped from `ts`=0 count.

Source files
------------

// File: rtl/seq_match_logger_if.sv
// Match-event read port: timestamp of the oldest buffered match with valid/ready.
// Latency: none, this is a plain signal bundle.
// Backpressure: the consumer holds out_ready low to stall; the producer keeps out_ts stable.
interface seq_match_logger_if #(
    parameter int TS_W = 16
);
    logic            out_valid;
    logic            out_ready;
    logic [TS_W-1:0] out_ts;

    // Logger side: presents entries, observes ready.
    modport master (output out_valid, output out_ts, input out_ready);
    // Consumer side: observes entries, drives ready.
    modport slave  (input out_valid, input out_ts, output out_ready);
endinterface

// File: rtl/seq_match_logger.sv
// Timestamps detector match pulses into a small FIFO, counts matches (saturating), flags drops.
// Latency: a match in cycle N is visible on out_valid/out_ts from cycle N+1; no bypass.
// Backpressure: a full FIFO drops new matches (sticky overflow) unless a pop occurs in the same cycle.
module seq_match_logger #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     match,
    input  logic                     clear,
    seq_match_logger_if.master       evt,
    output logic [$clog2(DEPTH):0]   fill,
    output logic [CNT_W-1:0]         match_count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [TS_W-1:0] ts;
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [TS_W-1:0] mem [DEPTH];

    logic empty;
    logic full;
    logic pop;
    logic push;
    logic drop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // clear overrides everything in the same cycle: no pop, no store, no count.
    assign pop  = !empty && evt.out_ready && !clear;
    assign push = match && !clear && (!full || pop);
    assign drop = match && !clear && full && !pop;

    // Outputs decode from registers only.
    assign evt.out_valid = !empty;
    assign evt.out_ts    = mem[rd_ptr[AW-1:0]];
    assign fill          = wr_ptr - rd_ptr;

    // Free-running timestamp; the pre-increment value is what a push stores.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts <= '0;
        end else if (clear) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_W'(1);
        end
    end

    // FIFO pointer update; a flush simply re-aligns both pointers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Entry storage needs no reset: contents are only observed while out_valid is high.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= ts;
    end

    // Match counter counts pushed and dropped matches alike, pinned at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match_count <= '0;
        end else if (clear) begin
            match_count <= '0;
        end else if (match && (match_count != {CNT_W{1'b1}})) begin
            match_count <= match_count + CNT_W'(1);
        end
    end

    // Sticky drop flag, released only by clear or reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (clear) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_seq_match_logger.sv
// Bench for seq_match_logger: a default instance and a narrow one (TS_W=4, CNT_W=2) share stimulus.
// Latency: the queue model updates on each rising edge; outputs are compared on the falling edge.
// Backpressure: out_ready is driven by the bench, directed first, then random.
module tb_seq_match_logger;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic match = 1'b0;
    logic clear = 1'b0;
    logic out_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    seq_match_logger_if #(.TS_W(16)) ifa ();
    seq_match_logger_if #(.TS_W(4))  ifb ();
    assign ifa.out_ready = out_ready;
    assign ifb.out_ready = out_ready;

    logic [2:0]  fill_a, fill_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;
    logic        ov_a, ov_b;

    seq_match_logger #(.TS_W(16), .DEPTH(DEPTH), .CNT_W(16)) dut_a (
        .clk(clk), .reset(rst_n), .match(match), .clear(clear),
        .evt(ifa), .fill(fill_a), .match_count(cnt_a), .overflow(ov_a)
    );

    seq_match_logger #(.TS_W(4), .DEPTH(DEPTH), .CNT_W(2)) dut_b (
        .clk(clk), .reset(rst_n), .match(match), .clear(clear),
        .evt(ifb), .fill(fill_b), .match_count(cnt_b), .overflow(ov_b)
    );

    always #5 clk = ~clk;

    // Behavioural model: each logger is a timestamp queue of capacity DEPTH plus counters.
    int unsigned qa[$];
    int unsigned qb[$];
    int unsigned tsa = 0, tsb = 0, ca = 0, cb = 0;
    bit ova = 1'b0, ovb = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clear) begin
            qa.delete(); qb.delete();
            tsa = 0; tsb = 0; ca = 0; cb = 0; ova = 1'b0; ovb = 1'b0;
        end else begin
            if (out_ready && qa.size() != 0) void'(qa.pop_front());
            if (out_ready && qb.size() != 0) void'(qb.pop_front());
            if (match) begin
                if (ca < 65535) ca = ca + 1;
                if (cb < 3) cb = cb + 1;
                if (qa.size() < DEPTH) qa.push_back(tsa); else ova = 1'b1;
                if (qb.size() < DEPTH) qb.push_back(tsb); else ovb = 1'b1;
            end
            tsa = (tsa + 1) % 65536;
            tsb = (tsb + 1) % 16;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Continuous comparison against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("a_valid", 32'(ifa.out_valid), 32'(qa.size() != 0));
            chk("a_fill",  32'(fill_a), qa.size());
            chk("a_count", 32'(cnt_a), ca);
            chk("a_ovf",   32'(ov_a), 32'(ova));
            if (qa.size() != 0) chk("a_ts", 32'(ifa.out_ts), qa[0]);
            chk("b_valid", 32'(ifb.out_valid), 32'(qb.size() != 0));
            chk("b_fill",  32'(fill_b), qb.size());
            chk("b_count", 32'(cnt_b), cb);
            chk("b_ovf",   32'(ov_b), 32'(ovb));
            if (qb.size() != 0) chk("b_ts", 32'(ifb.out_ts), qb[0]);
        end
    end

    initial begin
        // Reset state.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(ifa.out_valid), 0);
        chk("rst_fill",  32'(fill_a), 0);
        chk("rst_count", 32'(cnt_a), 0);
        chk("rst_ovf",   32'(ov_a), 0);
        tick(); tick();
        rst_n = 1'b1;

        // Single match at ts=5 with the consumer stalled.
        repeat (5) tick();
        match = 1'b1; tick(); match = 1'b0;
        chk("t1_valid", 32'(ifa.out_valid), 1);
        chk("t1_ts",    32'(ifa.out_ts), 5);
        chk("t1_fill",  32'(fill_a), 1);
        chk("t1_count", 32'(cnt_a), 1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Matches at ts 2,3,4,7, then back-to-back drain.
        clear = 1'b1; tick(); clear = 1'b0;
        tick(); tick();
        match = 1'b1; repeat (3) tick();
        match = 1'b0; repeat (2) tick();
        match = 1'b1; tick(); match = 1'b0;
        chk("t2_fill4", 32'(fill_a), 4);
        chk("t2_head2", 32'(ifa.out_ts), 2);
        out_ready = 1'b1;
        tick(); chk("t2_head3", 32'(ifa.out_ts), 3);
        tick(); chk("t2_head4", 32'(ifa.out_ts), 4);
        tick(); chk("t2_head7", 32'(ifa.out_ts), 7);
        tick();
        chk("t2_empty", 32'(ifa.out_valid), 0);
        chk("t2_fill0", 32'(fill_a), 0);
        out_ready = 1'b0;

        // Fill, drop the fifth match, then match and pop together when full.
        clear = 1'b1; tick(); clear = 1'b0;
        match = 1'b1; repeat (5) tick(); match = 1'b0;
        chk("t3_ovf",    32'(ov_a), 1);
        chk("t3_fill",   32'(fill_a), 4);
        chk("t3_count",  32'(cnt_a), 5);
        chk("t3_head",   32'(ifa.out_ts), 0);
        chk("t3_satcnt", 32'(cnt_b), 3);
        match = 1'b1; out_ready = 1'b1; tick(); match = 1'b0;
        chk("t3_fillx",  32'(fill_a), 4);
        chk("t3_headx",  32'(ifa.out_ts), 1);
        chk("t3_countx", 32'(cnt_a), 6);

        // Clear wins over a simultaneous match and pop.
        tick();
        match = 1'b1; repeat (3) tick();
        chk("t4_fill3",  32'(fill_a), 3);
        chk("t4_count9", 32'(cnt_a), 9);
        chk("t4_ovf1",   32'(ov_a), 1);
        clear = 1'b1; tick(); clear = 1'b0; out_ready = 1'b0;
        chk("t4_valid", 32'(ifa.out_valid), 0);
        chk("t4_fill",  32'(fill_a), 0);
        chk("t4_count", 32'(cnt_a), 0);
        chk("t4_ovf",   32'(ov_a), 0);
        tick(); match = 1'b0;
        chk("t4_ts0", 32'(ifa.out_ts), 0);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Timestamp wrap on the 4-bit instance.
        clear = 1'b1; tick(); clear = 1'b0;
        repeat (15) tick();
        match = 1'b1; tick(); tick(); match = 1'b0;
        chk("t5_b15", 32'(ifb.out_ts), 15);
        chk("t5_a15", 32'(ifa.out_ts), 15);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("t5_b0",  32'(ifb.out_ts), 0);
        chk("t5_a16", 32'(ifa.out_ts), 16);
        match = 1'b1; tick(); match = 1'b0;
        chk("t6_fill2", 32'(fill_a), 2);

        // Asynchronous reset mid-drain, checked before any clock edge.
        out_ready = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(ifa.out_valid), 0);
        chk("t6_fill",  32'(fill_a), 0);
        chk("t6_count", 32'(cnt_b), 0);
        chk("t6_ovf",   32'(ov_a), 0);
        tick();
        rst_n = 1'b1; out_ready = 1'b0; match = 1'b1;
        tick(); match = 1'b0;
        chk("t6_ts0",    32'(ifa.out_ts), 0);
        chk("t6_count1", 32'(cnt_a), 1);
        out_ready = 1'b1; tick();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            match     = ($urandom_range(0, 99) < 45);
            out_ready = ($urandom_range(0, 99) < 40);
            clear     = ($urandom_range(0, 99) < 2);
            rst_n     = ($urandom_range(0, 999) >= 4);
            tick();
        end
        rst_n = 1'b1; match = 1'b0; clear = 1'b0; out_ready = 1'b0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
